feed_replay_source: RTL and testbench

//  Avalon-ST source that replays a pre-loaded beat sequence onto a feed interface
//  (valid/ready/startofpacket/endofpacket/data/empty). It is the driving end of the

---
 rtl/feed_replay_source.sv | 149 ++++++++++++++
 tb/tb_feed_replay_source.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/feed_replay_source.sv
// feed_replay_source: Avalon-ST source that replays a pre-loaded beat table with per-beat idle gaps.
module feed_replay_source #(
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3,
  parameter int DEPTH   = 256,
  parameter int GAP_W   = 8,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_valid,
  input  logic               load_sop,
  input  logic               load_eop,
  input  logic [EMPTY_W-1:0] load_empty,
  input  logic [GAP_W-1:0]   load_gap,
  input  logic [DATA_W-1:0]  load_data,
  output logic               load_full,
  input  logic               clear,
  input  logic               start,
  input  logic               loop,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               framing_err,
  output logic [CNT_W-1:0]   beat_count,
  output logic               valid,
  input  logic               ready,
  output logic               startofpacket,
  output logic               endofpacket,
  output logic [DATA_W-1:0]  data,
  output logic [EMPTY_W-1:0] empty
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int NUM_W = IDX_W + 1;
  typedef enum logic [2:0] {IDLE, FETCH, GAP, SEND, DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [GAP_W-1:0] mem_gap [DEPTH];
  logic [EMPTY_W-1:0] mem_empty [DEPTH];
  logic mem_sop [DEPTH];
  logic mem_eop [DEPTH];
  logic [NUM_W-1:0] num_q, num_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, ptr_nxt;
  logic [GAP_W-1:0] gap_q, gap_d, gap_nxt;
  logic loop_q, loop_d, abort_q, abort_d, in_pkt_q, in_pkt_d, ferr_q, ferr_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic idle_like, wr_en, accept, last, abort_eff, cur_sop, cur_eop;
  assign idle_like = state_q == IDLE || state_q == DONE;
  assign load_full = num_q == NUM_W'(DEPTH);
  assign wr_en = idle_like && load_valid && !clear && !load_full;
  assign cur_sop = mem_sop[ptr_q];
  assign cur_eop = mem_eop[ptr_q];
  assign valid = state_q == SEND;
  assign accept = valid && ready;
  assign last = {1'b0, ptr_q} == num_q - NUM_W'(1);
  assign abort_eff = abort_q || abort;
  assign ptr_nxt = ptr_q + IDX_W'(1);
  assign gap_nxt = mem_gap[ptr_nxt];
  assign busy = state_q == FETCH || state_q == GAP || state_q == SEND;
  assign done = state_q == DONE;
  assign framing_err = ferr_q;
  assign beat_count = beats_q;
  assign startofpacket = valid && cur_sop;
  assign endofpacket = valid && cur_eop;
  assign data = valid ? mem_data[ptr_q] : '0;
  assign empty = valid ? mem_empty[ptr_q] : '0;
  always_comb begin
    state_d = state_q;
    num_d = num_q;
    ptr_d = ptr_q;
    gap_d = gap_q;
    loop_d = loop_q;
    abort_d = abort_q;
    in_pkt_d = in_pkt_q;
    ferr_d = ferr_q;
    beats_d = beats_q;
    case (state_q)
      IDLE, DONE: begin
        num_d = clear ? '0 : num_q + NUM_W'(wr_en);
        if (clear) state_d = IDLE;
        else if (start) begin
          state_d = num_q == '0 ? DONE : FETCH;
          ptr_d = '0;
          loop_d = loop;
          abort_d = 1'b0;
          in_pkt_d = 1'b0;
          ferr_d = 1'b0;
          beats_d = '0;
        end
      end
      FETCH: begin
        abort_d = abort_eff;
        state_d = abort_eff && !in_pkt_q ? DONE : GAP;
        gap_d = mem_gap[ptr_q];
      end
      GAP: begin
        abort_d = abort_eff;
        state_d = abort_eff && !in_pkt_q ? DONE : gap_q == '0 ? SEND : GAP;
        gap_d = gap_q - GAP_W'(1);
      end
      SEND: begin
        abort_d = abort_eff;
        if (accept) begin
          beats_d = beats_q + CNT_W'(1);
          in_pkt_d = !cur_eop;
          // sop inside a packet or non-sop outside one both reduce to sop == in_pkt
          ferr_d = ferr_q || (cur_sop == in_pkt_q);
          ptr_d = last ? '0 : ptr_nxt;
          gap_d = gap_nxt - GAP_W'(1);
          state_d = (abort_eff && cur_eop) || (last && (!loop_q || abort_eff)) ? DONE :
                    last ? FETCH : gap_nxt == '0 ? SEND : GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      num_q <= '0;
      ptr_q <= '0;
      gap_q <= '0;
      loop_q <= 1'b0;
      abort_q <= 1'b0;
      in_pkt_q <= 1'b0;
      ferr_q <= 1'b0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      num_q <= num_d;
      ptr_q <= ptr_d;
      gap_q <= gap_d;
      loop_q <= loop_d;
      abort_q <= abort_d;
      in_pkt_q <= in_pkt_d;
      ferr_q <= ferr_d;
      beats_q <= beats_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[num_q[IDX_W-1:0]] <= load_data;
      mem_gap[num_q[IDX_W-1:0]] <= load_gap;
      mem_empty[num_q[IDX_W-1:0]] <= load_empty;
      mem_sop[num_q[IDX_W-1:0]] <= load_sop;
      mem_eop[num_q[IDX_W-1:0]] <= load_eop;
    end
  end
endmodule

// File: tb/tb_feed_replay_source.sv
// tb_feed_replay_source: scoreboard bench; the driver predicts beats and timing, a monitor checks accepts.
module tb_feed_replay_source;
  typedef struct { logic [63:0] d; logic s; logic e; logic [2:0] m; int lead; } beat_t;
  logic clk = 0, reset_n = 0, load_valid = 0, load_sop = 0, load_eop = 0;
  logic clear = 0, start = 0, loop = 0, abort = 0, ready = 0;
  logic [2:0] load_empty = 0;
  logic [7:0] load_gap = 0;
  logic [63:0] load_data = 0;
  logic load_full, busy, done, framing_err, valid, startofpacket, endofpacket;
  logic [31:0] beat_count;
  logic [63:0] data;
  logic [2:0] empty;
  beat_t ent[$];
  beat_t exp_q[$];
  beat_t mb;
  int held_log[$];
  int cyc = 0, n_chk = 0, n_fail = 0, acc_cnt = 0, ref_edge = 0, start_edge = 0;
  int rmode = 0, stall = 0, held = 0;
  logic pend = 0, prev_stall = 0, prev_s = 0, prev_e = 0;
  logic [63:0] prev_d = 0;
  logic [2:0] prev_m = 0;

  feed_replay_source dut (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_sop(load_sop),
    .load_eop(load_eop), .load_empty(load_empty), .load_gap(load_gap), .load_data(load_data),
    .load_full(load_full), .clear(clear), .start(start), .loop(loop), .abort(abort),
    .busy(busy), .done(done), .framing_err(framing_err), .beat_count(beat_count),
    .valid(valid), .ready(ready), .startofpacket(startofpacket), .endofpacket(endofpacket),
    .data(data), .empty(empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ready policy: 0 always, 1 random, 2 stall the second beat 4 cycles, 3 never
  always @(posedge clk) begin
    #1;
    if (rmode == 0) ready = 1;
    else if (rmode == 1) ready = 1'($urandom_range(0, 1));
    else if (rmode == 2) begin
      if (acc_cnt == 1 && valid && stall < 4) begin ready = 0; stall++; end
      else ready = 1;
    end else ready = 0;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      pend = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("valid_held", 64'(valid), 64'(1));
        chk("data_held", data, prev_d);
        chk("flags_held", 64'({startofpacket, endofpacket, empty}), 64'({prev_s, prev_e, prev_m}));
      end
      if (valid && !pend) begin
        pend = 1;
        held = 0;
        chk("beat_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) chk("beat_timing", 64'(cyc), 64'(ref_edge + exp_q[0].lead));
      end
      if (valid) held++;
      if (valid && ready) begin
        if (exp_q.size() > 0) begin
          mb = exp_q.pop_front();
          chk("data", data, mb.d);
          chk("sop", 64'(startofpacket), 64'(mb.s));
          chk("eop", 64'(endofpacket), 64'(mb.e));
          chk("empty", 64'(empty), 64'(mb.m));
        end
        acc_cnt++;
        ref_edge = cyc + 1;
        pend = 0;
        held_log.push_back(held);
      end
      prev_stall = valid && !ready;
      prev_d = data;
      prev_s = startofpacket;
      prev_e = endofpacket;
      prev_m = empty;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input logic s, input logic e, input logic [2:0] m, input logic [7:0] g,
                           input logic [63:0] d);
    load_valid = 1; load_sop = s; load_eop = e; load_empty = m; load_gap = g; load_data = d;
    tick();
    load_valid = 0;
    if (ent.size() < 256) ent.push_back('{d: d, s: s, e: e, m: m, lead: int'(g)});
  endtask

  task automatic do_clear();
    clear = 1;
    tick();
    clear = 0;
    ent.delete();
  endtask

  // the first beat of each pass appears 2+gap cycles after start or after the previous pass ends
  task automatic do_start(input logic lp, input int rounds);
    acc_cnt = 0;
    held_log.delete();
    for (int r = 0; r < rounds; r++)
      for (int i = 0; i < ent.size(); i++) begin
        beat_t b;
        b = ent[i];
        if (i == 0) b.lead = 2 + b.lead;
        exp_q.push_back(b);
      end
    start = 1; loop = lp;
    ref_edge = cyc + 1;
    start_edge = cyc + 1;
    tick();
    start = 0; loop = 0;
  endtask

  task automatic wait_done(output int dc);
    int i;
    i = 0;
    while (!done && i < 5000) begin tick(); i++; end
    chk("done_reached", 64'(done), 64'(1));
    dc = cyc;
  endtask

  initial begin
    int dc;
    int len;
    repeat (3) tick();
    chk("rst_valid", 64'(valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_full", 64'(load_full), 0);
    chk("rst_ferr", 64'(framing_err), 0);
    chk("rst_count", 64'(beat_count), 0);
    chk("rst_payload", 64'({startofpacket, endofpacket, empty}) | data, 0);
    reset_n = 1;
    tick();
    // three-beat packet at full throughput
    load_beat(1, 0, 0, 0, 64'd1); load_beat(0, 0, 0, 0, 64'd2); load_beat(0, 1, 3, 0, 64'd3);
    rmode = 0;
    tick();
    do_start(0, 1);
    chk("t1_busy", 64'(busy), 1);
    wait_done(dc);
    chk("t1_done_cycle", 64'(dc), 64'(start_edge + 5));
    chk("t1_beats", 64'(beat_count), 3);
    chk("t1_ferr", 64'(framing_err), 0);
    chk("t1_drained", 64'(exp_q.size()), 0);
    // backpressure on beat 2
    rmode = 2; stall = 0;
    do_start(0, 1);
    wait_done(dc);
    chk("t2_hold", 64'(held_log.size() > 1 ? held_log[1] : -1), 5);
    chk("t2_done_cycle", 64'(dc), 64'(start_edge + 9));
    chk("t2_beats", 64'(beat_count), 3);
    chk("t2_drained", 64'(exp_q.size()), 0);
    // gaps {0,5,0}
    rmode = 0;
    do_clear();
    load_beat(1, 0, 1, 0, 64'h11); load_beat(0, 0, 2, 5, 64'h22); load_beat(0, 1, 4, 0, 64'h33);
    do_start(0, 1);
    wait_done(dc);
    chk("t3_done_cycle", 64'(dc), 64'(start_edge + 10));
    chk("t3_beats", 64'(beat_count), 3);
    chk("t3_drained", 64'(exp_q.size()), 0);
    // loop with abort during the third pass
    do_clear();
    load_beat(1, 0, 0, 0, 64'hA0); load_beat(0, 1, 5, 0, 64'hA1);
    rmode = 1;
    do_start(1, 3);
    for (int i = 0; i < 500 && acc_cnt < 5; i++) tick();
    chk("t4_progress", 64'(acc_cnt >= 5), 1);
    abort = 1;
    tick();
    abort = 0;
    wait_done(dc);
    chk("t4_beats", 64'(beat_count), 6);
    chk("t4_even", 64'(beat_count[0]), 0);
    chk("t4_drained", 64'(exp_q.size()), 0);
    // framing violation, cleared by the next start
    do_clear();
    load_beat(0, 1, 0, 0, 64'h7); load_beat(1, 1, 0, 0, 64'h8);
    do_start(0, 1);
    wait_done(dc);
    chk("t5_ferr_set", 64'(framing_err), 1);
    do_start(0, 1);
    chk("t5_ferr_cleared", 64'(framing_err), 0);
    wait_done(dc);
    chk("t5_ferr_again", 64'(framing_err), 1);
    chk("t5_drained", 64'(exp_q.size()), 0);
    // clear beats a simultaneous load
    clear = 1; load_valid = 1; load_sop = 1; load_eop = 1; load_data = 64'h99;
    tick();
    clear = 0; load_valid = 0;
    ent.delete();
    do_start(0, 1);
    chk("t5_empty_done", 64'(done), 1);
    chk("t5_empty_beats", 64'(beat_count), 0);
    // full table of random well-formed packets under random backpressure
    while (ent.size() < 256) begin
      len = $urandom_range(1, 4);
      for (int k = 0; k < len && ent.size() < 256; k++)
        load_beat(k == 0, k == len - 1 || ent.size() == 255, 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 3)), {$urandom, $urandom});
    end
    chk("t6_full", 64'(load_full), 1);
    load_beat(1, 1, 0, 0, 64'hDEAD_BEEF_0BAD_F00D);
    chk("t6_still_full", 64'(load_full), 1);
    do_start(0, 1);
    wait_done(dc);
    chk("t6_beats", 64'(beat_count), 256);
    chk("t6_ferr", 64'(framing_err), 0);
    chk("t6_drained", 64'(exp_q.size()), 0);
    // reset while a beat is stalled
    rmode = 3;
    do_start(0, 1);
    for (int i = 0; i < 20 && !valid; i++) tick();
    chk("t7_valid_seen", 64'(valid), 1);
    reset_n = 0;
    tick();
    chk("t7_valid", 64'(valid), 0);
    chk("t7_busy", 64'(busy), 0);
    chk("t7_done", 64'(done), 0);
    chk("t7_full", 64'(load_full), 0);
    chk("t7_count", 64'(beat_count), 0);
    reset_n = 1;
    ent.delete();
    rmode = 0;
    tick();
    do_start(0, 1);
    chk("t7_empty_done", 64'(done), 1);
    chk("t7_empty_beats", 64'(beat_count), 0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
